// File: rtl/dffram_pin_pkg.sv
// Shared definitions for the DFFRAM byte-serial pin host.
// Contents: ctrl byte field positions, lane one-hot constants, host FSM state
// enum, and small helpers that pick a lane and assemble a ctrl byte.
package dffram_pin_pkg;

  localparam int NUM_LANES     = 4;
  localparam int CTRL_LANE_LSB = 0;
  localparam int CTRL_LANE_MSB = 3;
  localparam int CTRL_EN_BIT   = 4;
  localparam int CTRL_ADDR_LSB = 5;
  localparam int CTRL_ADDR_MSB = 7;
  localparam int CTRL_ADDR_W   = CTRL_ADDR_MSB - CTRL_ADDR_LSB + 1;

  localparam logic [NUM_LANES-1:0] LANE_NONE = 4'b0000;
  localparam logic [NUM_LANES-1:0] LANE0_OH  = 4'b0001;
  localparam logic [NUM_LANES-1:0] LANE1_OH  = 4'b0010;
  localparam logic [NUM_LANES-1:0] LANE2_OH  = 4'b0100;
  localparam logic [NUM_LANES-1:0] LANE3_OH  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_LANE,
    ST_TRST,
    ST_RD_CMD,
    ST_RD_WAIT,
    ST_RD_CAP,
    ST_RSP,
    ST_GAP
  } host_state_e;

  // Index of the lowest set lane; lanes are issued in ascending order.
  function automatic logic [1:0] lowest_lane(input logic [NUM_LANES-1:0] lanes);
    lowest_lane = 2'd0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (lanes[k]) lowest_lane = 2'(k);
    end
  endfunction

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    lane_onehot = LANE0_OH;
      2'd1:    lane_onehot = LANE1_OH;
      2'd2:    lane_onehot = LANE2_OH;
      default: lane_onehot = LANE3_OH;
    endcase
  endfunction

  function automatic logic [7:0] make_ctrl(input logic [CTRL_ADDR_W-1:0] addr,
                                           input logic                   en,
                                           input logic [NUM_LANES-1:0]   lane);
    make_ctrl = '0;
    make_ctrl[CTRL_ADDR_MSB:CTRL_ADDR_LSB] = addr;
    make_ctrl[CTRL_EN_BIT]                 = en;
    make_ctrl[CTRL_LANE_MSB:CTRL_LANE_LSB] = lane;
  endfunction

endpackage

// File: rtl/dffram_pin_capture.sv
// Read-byte collector: shifts target bytes in LSB-first, one per enabled edge.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   en          sample byte_i on this edge (host is in its capture phase)
//   byte_i      target data byte
//   word_next   assembled word including the byte being sampled this edge
//   done        this edge samples the last byte of the word
module dffram_pin_capture
  import dffram_pin_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [7:0]               byte_i,
  output logic [8*NUM_LANES-1:0]   word_next,
  output logic                     done
);

  // Only the first three bytes need storage; the fourth is taken straight
  // from the pins on the final edge so the word is ready in the same cycle.
  logic [8*(NUM_LANES-1)-1:0] sr_q;
  logic [1:0]                 lane_q;

  assign word_next = {byte_i, sr_q};
  assign done      = en && (lane_q == 2'(NUM_LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      lane_q <= '0;
    end else if (en) begin
      sr_q   <= {byte_i, sr_q[8*(NUM_LANES-1)-1:8]};
      lane_q <= lane_q + 2'd1;
    end
  end

endmodule

// File: rtl/dffram_pin_host.sv
// Host-side initiator for the byte-serial DFFRAM pin interface (8 x 32 bit).
// Turns word read/write requests into per-byte pin cycles and returns read
// words assembled LSB-first. Every output is a flop.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake, accept = valid & ready
//   req_we/addr/be/wdata       request fields, latched at accept
//   rsp_valid/rsp_rdata        one-cycle completion pulse and read word
//   busy                       transaction in flight
//   pin_data_o/pin_ctrl_o      byte and {addr,en,lane} to the target
//   pin_rdata_i                byte from the target
//   tgt_rst_n_o                target reset, pulsed before each read
//
// state      | meaning
// IDLE       | ready for a request
// WR_LANE    | one write byte cycle per enabled lane, ascending
// TRST       | target reset low, clears its output rotation
// RD_CMD     | read command cycle, ctrl = {addr,1,0000}
// RD_WAIT    | target read latency, pins idle
// RD_CAP     | four byte captures, pins idle
// RSP        | rsp_valid pulse
// GAP        | idle pin cycles before the next request
module dffram_pin_host
  import dffram_pin_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int RD_LAT      = 2,
  parameter int TGT_RST_CYC = 1,
  parameter int GAP_CYC     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              busy,
  output logic [7:0]        pin_data_o,
  output logic [7:0]        pin_ctrl_o,
  input  logic [7:0]        pin_rdata_i,
  output logic              tgt_rst_n_o
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] TRST_LOAD = CNT_W'((TGT_RST_CYC > 0) ? TGT_RST_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  host_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        lanes_q, lanes_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              accept;
  logic [3:0]        lanes_src;
  logic [ADDR_W-1:0] addr_src;
  logic [31:0]       wdata_src;
  logic [1:0]        lane_idx;
  logic [3:0]        lane_oh;

  logic              cap_en, cap_done;
  logic [31:0]       cap_word;

  logic              ready_d, busy_d, rsp_valid_d, tgt_rst_n_d;
  logic [7:0]        ctrl_d, data_d;
  logic [31:0]       rdata_d;

  assign accept = req_valid && req_ready;

  // The first write lane is driven on the accept edge itself, so the request
  // fields are used directly in IDLE and from the latched copy afterwards.
  always_comb begin
    lanes_src = (state_q == ST_IDLE) ? req_be    : lanes_q;
    addr_src  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    wdata_src = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    lane_idx  = lowest_lane(lanes_src);
    lane_oh   = lane_onehot(lane_idx);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    rdata_d = rsp_rdata;
    cap_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_we) begin
            rdata_d = '0;
            state_d = (req_be == 4'b0000) ? ST_RSP : ST_WR_LANE;
          end else if (TGT_RST_CYC > 0) begin
            state_d = ST_TRST;
            cnt_d   = TRST_LOAD;
          end else begin
            state_d = ST_RD_CMD;
          end
        end
      end
      ST_WR_LANE: begin
        if (lanes_q == 4'b0000) begin
          state_d = ST_RSP;
          rdata_d = '0;
        end
      end
      ST_TRST: begin
        if (cnt_q == '0) state_d = ST_RD_CMD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RD_CMD: begin
        if (RD_LAT > 0) begin
          state_d = ST_RD_WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = ST_RD_CAP;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) state_d = ST_RD_CAP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RD_CAP: begin
        cap_en = 1'b1;
        if (cap_done) begin
          state_d = ST_RSP;
          rdata_d = cap_word;
        end
      end
      ST_RSP: begin
        if (GAP_CYC > 0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are decoded from the state being entered.
    ready_d     = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_RSP);
    tgt_rst_n_d = (state_d != ST_TRST);
    ctrl_d      = '0;
    data_d      = '0;
    if (state_d == ST_WR_LANE) begin
      ctrl_d  = make_ctrl(addr_src, 1'b1, lane_oh);
      data_d  = wdata_src[{lane_idx, 3'b000} +: 8];
      lanes_d = lanes_src & ~lane_oh;
    end
    if (state_d == ST_RD_CMD) begin
      ctrl_d = make_ctrl(addr_src, 1'b1, LANE_NONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lanes_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready   <= 1'b0;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      pin_ctrl_o  <= '0;
      pin_data_o  <= '0;
      tgt_rst_n_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lanes_q     <= lanes_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      req_ready   <= ready_d;
      busy        <= busy_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rdata_d;
      pin_ctrl_o  <= ctrl_d;
      pin_data_o  <= data_d;
      tgt_rst_n_o <= tgt_rst_n_d;
    end
  end

  dffram_pin_capture u_capture (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (cap_en),
    .byte_i    (pin_rdata_i),
    .word_next (cap_word),
    .done      (cap_done)
  );

endmodule

// File: tb/tb_dffram_pin_host.sv
// Bench for dffram_pin_host: directed vector table, back-to-back and
// mid-read reset sequences, then random traffic against a word-level
// memory model. A behavioural target on the pins stores written bytes and
// returns read bytes after the command, so writes are checked end to end.
module tb_dffram_pin_host;

  localparam int RD_LAT      = 2;
  localparam int TGT_RST_CYC = 1;
  localparam int GAP_CYC     = 1;
  localparam int RD_TOTAL    = TGT_RST_CYC + 1 + RD_LAT + 4 + 1;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [7:0]  pin_data_o, pin_ctrl_o, pin_rdata_i;
  logic        tgt_rst_n_o;

  dffram_pin_host #(
    .ADDR_W(3), .RD_LAT(RD_LAT), .TGT_RST_CYC(TGT_RST_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .pin_data_o(pin_data_o), .pin_ctrl_o(pin_ctrl_o),
    .pin_rdata_i(pin_rdata_i), .tgt_rst_n_o(tgt_rst_n_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [8];
  logic [31:0] tgt_mem [8];

  int          act_cyc  [$];
  logic [7:0]  act_ctrl [$];
  logic [7:0]  act_data [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural pin target. Observes each cycle at the falling edge and sets
  // the byte the host samples on the following rising edge. Its output
  // pointer only rewinds on a target reset; without one it returns 0xEE.
  int         tgt_ptr;
  int         tgt_cnt;
  bit         tgt_rd;
  logic [2:0] tgt_addr;
  initial begin
    logic [7:0] c;
    for (int i = 0; i < 8; i++) tgt_mem[i] = 32'h0;
    tgt_mem[7] = 32'h44332211;
    tgt_ptr = 0; tgt_cnt = 0; tgt_rd = 0; tgt_addr = '0;
    pin_rdata_i = 8'h00;
    forever begin
      @(negedge clk);
      c = pin_ctrl_o;
      if (!tgt_rst_n_o) begin
        tgt_ptr = 0;
        tgt_rd  = 0;
      end
      if (c[4]) begin
        if (c[3:0] == 4'b0000) begin
          tgt_rd = 1; tgt_cnt = 0; tgt_addr = c[7:5];
        end else begin
          for (int k = 0; k < 4; k++)
            if (c[k]) tgt_mem[c[7:5]][8*k +: 8] = pin_data_o;
        end
        pin_rdata_i = 8'($urandom);
      end else if (tgt_rd) begin
        tgt_cnt++;
        if (tgt_cnt >= RD_LAT + 1 && tgt_cnt <= RD_LAT + 4) begin
          pin_rdata_i = (tgt_ptr < 4) ? tgt_mem[tgt_addr][8*tgt_ptr +: 8] : 8'hEE;
          tgt_ptr++;
          if (tgt_cnt == RD_LAT + 4) tgt_rd = 0;
        end else begin
          pin_rdata_i = 8'($urandom);
        end
      end else begin
        pin_rdata_i = 8'($urandom);
      end
    end
  end

  task automatic run_txn(input logic we, input logic [2:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input int exp_lat,
                         input logic [31:0] exp_rd, input string tag);
    int          lat, idle_bad, busy_bad, trst_cnt, trst_first, j;
    logic [31:0] rd;
    bit          got;
    int          exp_cyc  [$];
    logic [7:0]  exp_ctrl [$];
    logic [7:0]  exp_data [$];
    // expected pin activity from the protocol rules
    j = 0;
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          j++;
          exp_cyc.push_back(j);
          exp_ctrl.push_back({addr, 1'b1, 4'(1 << k)});
          exp_data.push_back(wd[8*k +: 8]);
        end
      end
    end else begin
      exp_cyc.push_back(TGT_RST_CYC + 1);
      exp_ctrl.push_back({addr, 1'b1, 4'b0000});
      exp_data.push_back(8'h00);
    end

    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
    got = 0;
    for (int w = 0; w < 40 && !got; w++) begin
      @(negedge clk);
      got = req_ready;
    end
    chk({tag, "_accept"}, 32'(got), 32'd1);
    if (!got) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = 3'($urandom); req_be = 4'($urandom); req_wdata = $urandom;
    if (we)
      for (int k = 0; k < 4; k++)
        if (be[k]) ref_mem[addr][8*k +: 8] = wd[8*k +: 8];

    act_cyc.delete(); act_ctrl.delete(); act_data.delete();
    lat = -1; rd = '0; idle_bad = 0; busy_bad = 0; trst_cnt = 0; trst_first = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (pin_ctrl_o != 8'h00) begin
        act_cyc.push_back(n); act_ctrl.push_back(pin_ctrl_o); act_data.push_back(pin_data_o);
      end else if (pin_data_o != 8'h00) idle_bad++;
      if (!tgt_rst_n_o) begin
        trst_cnt++;
        if (trst_first < 0) trst_first = n;
      end
      if (!busy || req_ready) busy_bad++;
      if (rsp_valid) begin
        lat = n; rd = rsp_rdata;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_n_pin_cycles"}, 32'(act_cyc.size()), 32'(exp_cyc.size()));
    for (int i = 0; i < exp_cyc.size() && i < act_cyc.size(); i++) begin
      chk($sformatf("%s_pin%0d_cycle", tag, i), 32'(act_cyc[i]), 32'(exp_cyc[i]));
      chk($sformatf("%s_pin%0d_ctrl", tag, i), 32'(act_ctrl[i]), 32'(exp_ctrl[i]));
      chk($sformatf("%s_pin%0d_data", tag, i), 32'(act_data[i]), 32'(exp_data[i]));
    end
    chk({tag, "_idle_data_nonzero"}, 32'(idle_bad), 32'd0);
    chk({tag, "_busy_ready_while_active"}, 32'(busy_bad), 32'd0);
    chk({tag, "_trst_cycles"}, 32'(trst_cnt), we ? 32'd0 : 32'(TGT_RST_CYC));
    if (!we) chk({tag, "_trst_first"}, 32'(trst_first), 32'd1);
    @(negedge clk);
    chk({tag, "_rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_gap_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_gap_ctrl"}, 32'(pin_ctrl_o), 32'd0);
    @(negedge clk);
    chk({tag, "_ready_after_gap"}, 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rd;
    logic [7:0]  first_ctrl;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int          acc, first_acc, second_acc, nrsp, ntrst, rd_bad;
    logic        we;
    logic [2:0]  a;
    logic [3:0]  be;
    logic [31:0] wd;

    for (int i = 0; i < 8; i++) ref_mem[i] = 32'h0;
    ref_mem[7] = 32'h44332211;

    tbl[0] = '{1'b1, 3'd5, 4'b1111, 32'hDEADBEEF, 5,        32'h0,        8'hB1};
    tbl[1] = '{1'b1, 3'd2, 4'b0101, 32'h12345678, 3,        32'h0,        8'h51};
    tbl[2] = '{1'b1, 3'd3, 4'b0000, 32'hFFFFFFFF, 1,        32'h0,        8'h00};
    tbl[3] = '{1'b0, 3'd7, 4'b0000, 32'h0,        RD_TOTAL, 32'h44332211, 8'hF0};
    tbl[4] = '{1'b0, 3'd5, 4'b1010, 32'h0,        RD_TOTAL, 32'hDEADBEEF, 8'hB0};
    tbl[5] = '{1'b0, 3'd2, 4'b0000, 32'h0,        RD_TOTAL, 32'h00340078, 8'h50};
    tbl[6] = '{1'b0, 3'd3, 4'b1111, 32'h0,        RD_TOTAL, 32'h00000000, 8'h70};

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_tgt_rst_n", 32'(tgt_rst_n_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pins", 32'({pin_ctrl_o, pin_data_o}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_tgt_rst_n", 32'(tgt_rst_n_o), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wd, tbl[i].lat, tbl[i].rd,
              $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_first_ctrl", i),
          32'((act_ctrl.size() > 0) ? act_ctrl[0] : 8'h00), 32'(tbl[i].first_ctrl));
    end

    // back-to-back reads with req_valid held high throughout
    acc = 0; first_acc = -1; second_acc = -1; nrsp = 0; ntrst = 0; rd_bad = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd5; req_be = 4'($urandom); req_wdata = $urandom;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        nrsp++;
        if (rsp_rdata !== ref_mem[5]) rd_bad++;
      end
      if (!tgt_rst_n_o) ntrst++;
      if (req_valid && req_ready) begin
        if (acc == 0) first_acc = n; else second_acc = n;
        acc++;
        if (acc == 2) begin
          @(posedge clk); #1;
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd2);
    chk("b2b_spacing", 32'(second_acc - first_acc), 32'(RD_TOTAL + GAP_CYC + 1));
    chk("b2b_rsp_count", 32'(nrsp), 32'd2);
    chk("b2b_trst_pulses", 32'(ntrst), 32'(2 * TGT_RST_CYC));
    chk("b2b_rdata_bad", 32'(rd_bad), 32'd0);

    // reset asserted during read capture
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd7;
    begin
      bit got;
      got = 0;
      for (int w = 0; w < 40 && !got; w++) begin
        @(negedge clk);
        got = req_ready;
      end
      chk("abort_accept", 32'(got), 32'd1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_pins", 32'({pin_ctrl_o, pin_data_o}), 32'd0);
    chk("abort_tgt_rst_n", 32'(tgt_rst_n_o), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    nrsp = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", 32'(req_ready), 32'd1);
    chk("abort_tgt_rst_n_after", 32'(tgt_rst_n_o), 32'd1);
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    chk("abort_no_rsp", 32'(nrsp), 32'd0);
    run_txn(1'b0, 3'd7, 4'b0000, 32'h0, RD_TOTAL, ref_mem[7], "abort_reread");

    // random traffic against the word-level model
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = 3'($urandom);
      be = 4'($urandom);
      wd = $urandom;
      run_txn(we, a, be, wd, we ? ($countones(be) + 1) : RD_TOTAL,
              we ? 32'h0 : ref_mem[a], $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
